// File: rtl/ln4490_bounce_eliminator_pkg.sv
// Shared types for the bounce eliminator: the kind of debounced transition
// a channel reports on a given clock edge.
package ln4490_bounce_eliminator_pkg;

  typedef enum logic [1:0] {
    EVT_NONE = 2'd0,
    EVT_RISE = 2'd1,
    EVT_FALL = 2'd2
  } evt_e;

endpackage

// File: rtl/ln4490_bounce_eliminator_channel.sv
// One debounce channel: 2-flop synchroniser, stability counter, debounced
// level and registered one-cycle rise/fall pulses.
module ln4490_channel
  import ln4490_bounce_eliminator_pkg::*;
#(
  parameter int STABLE_CNT = 4
) (
  input  logic cp,
  input  logic mr_n,
  input  logic in_raw,
  output logic out_q,
  output logic out_rise,
  output logic out_fall
);

  localparam int CNT_W = $clog2(STABLE_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

  logic             s1_q, s2_q;
  logic             lvl_q, lvl_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  evt_e             evt;

  // Any edge where the synchronised input agrees with the level restarts the count.
  always_comb begin
    cnt_d = '0;
    lvl_d = lvl_q;
    evt   = EVT_NONE;
    if (s2_q != lvl_q) begin
      if (cnt_q == CNT_LAST) begin
        lvl_d = s2_q;
        evt   = s2_q ? EVT_RISE : EVT_FALL;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    rise_d = (evt == EVT_RISE);
    fall_d = (evt == EVT_FALL);
  end

  always_ff @(posedge cp or negedge mr_n) begin
    if (!mr_n) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      cnt_q  <= '0;
      lvl_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s1_q   <= in_raw;
      s2_q   <= s1_q;
      cnt_q  <= cnt_d;
      lvl_q  <= lvl_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign out_q    = lvl_q;
  assign out_rise = rise_q;
  assign out_fall = fall_q;

endmodule

// File: rtl/ln4490_bounce_eliminator.sv
// Multi-channel switch bounce eliminator (CD4490/MC14490 style): independent
// debounce channels producing clean levels plus one-cycle edge pulses.
module ln4490_bounce_eliminator
  import ln4490_bounce_eliminator_pkg::*;
#(
  parameter int CHANNELS   = 6,
  parameter int STABLE_CNT = 4
) (
  input  logic                cp,
  input  logic                mr_n,
  input  logic [CHANNELS-1:0] in_raw,
  output logic [CHANNELS-1:0] out_q,
  output logic [CHANNELS-1:0] out_rise,
  output logic [CHANNELS-1:0] out_fall
);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    ln4490_channel #(
      .STABLE_CNT(STABLE_CNT)
    ) u_ch (
      .cp      (cp),
      .mr_n    (mr_n),
      .in_raw  (in_raw[g]),
      .out_q   (out_q[g]),
      .out_rise(out_rise[g]),
      .out_fall(out_fall[g])
    );
  end

endmodule
